// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- parametrised universal shift register with shift counter.
//
// Modes (when En=1): hold, shift right, shift left, parallel load,
// rotate right, rotate left, synchronous clear. Mode 111 is reserved and
// behaves as hold.
// A counter tracks shifts/rotates since the last load or clear and
// saturates at WIDTH. Done pulses for one cycle when the count reaches WIDTH.
//
// Ports:
//   Clk    in   rising-edge clock
//   Rst_n  in   asynchronous active-low reset
//   En     in   operation enable (0 = hold everything, Done=0)
//   Mode   in   [2:0] operation select
//   SinR   in   serial bit entering the MSB on shift right
//   SinL   in   serial bit entering the LSB on shift left
//   Din    in   [WIDTH-1:0] parallel load data
//   Q      out  [WIDTH-1:0] register contents
//   SoutR  out  Q[0]
//   SoutL  out  Q[WIDTH-1]
//   Cnt    out  [CW-1:0] shifts since last load/clear, saturating at WIDTH
//   Full   out  Cnt == WIDTH
//   Done   out  one-cycle pulse after the edge where Cnt reaches WIDTH
module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic             SinR,
  input  logic             SinL,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q,
  output logic             SoutR,
  output logic             SoutL,
  output logic [CW-1:0]    Cnt,
  output logic             Full,
  output logic             Done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  assign mode = mode_e'(Mode);

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    shift_op = 1'b0;
    if (En) begin
      case (mode)
        MODE_SHR: begin
          q_d      = {SinR, q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], SinL};
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = Din;
          cnt_d = '0;
        end
        MODE_ROTR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_ROTL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shift_op = 1'b1;
        end
        MODE_CLEAR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ; // MODE_HOLD and MODE_RSVD keep state
      endcase
    end
    if (shift_op && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Only the WIDTH-1 -> WIDTH transition fires Done; load/clear never
  // set shift_op, so they win over a pending saturation.
  assign done_d = shift_op && (cnt_q == CNT_MAX - 1'b1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q     = q_q;
  assign SoutR = q_q[0];
  assign SoutL = q_q[WIDTH-1];
  assign Cnt   = cnt_q;
  assign Full  = (cnt_q == CNT_MAX);
  assign Done  = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int CWB = $clog2(W + 1);

  logic           Clk;
  logic           Rst_n;
  logic           En;
  logic [2:0]     Mode;
  logic           SinR;
  logic           SinL;
  logic [W-1:0]   Din;
  logic [W-1:0]   Q;
  logic           SoutR;
  logic           SoutL;
  logic [CWB-1:0] Cnt;
  logic           Full;
  logic           Done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(
    .WIDTH   (W),
    .RST_VAL (8'hA5)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .En    (En),
    .Mode  (Mode),
    .SinR  (SinR),
    .SinL  (SinL),
    .Din   (Din),
    .Q     (Q),
    .SoutR (SoutR),
    .SoutL (SoutL),
    .Cnt   (Cnt),
    .Full  (Full),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic         sinr;
    logic         sinl;
    logic [W-1:0] din;
    logic [W-1:0] q;
    int           cnt;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [2:0] mode, input logic sinr,
                     input logic sinl, input logic [W-1:0] din,
                     input logic [W-1:0] q, input int cnt, input logic done);
    vec_t v;
    v.en = en; v.mode = mode; v.sinr = sinr; v.sinl = sinl; v.din = din;
    v.q = q; v.cnt = cnt; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] q, input int cnt,
                         input logic done);
    chk({tag, " Q"}, 32'(Q), 32'(q));
    chk({tag, " Cnt"}, 32'(Cnt), 32'(cnt));
    chk({tag, " Done"}, 32'(Done), 32'(done));
    chk({tag, " Full"}, 32'(Full), 32'(cnt == W));
    chk({tag, " SoutR"}, 32'(SoutR), 32'(q[0]));
    chk({tag, " SoutL"}, 32'(SoutL), 32'(q[W-1]));
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic en, input logic [2:0] mode, input logic sinr,
                      input logic sinl, input logic [W-1:0] din);
    En = en; Mode = mode; SinR = sinr; SinL = sinl; Din = din;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] expq;
    Rst_n = 1'b1; En = 1'b0; Mode = 3'b000; SinR = 1'b0; SinL = 1'b0; Din = '0;

    // ---- vector table ----
    // SISO: load 0, shift right pattern 1,0,1,1,0,0,1,0 then flush with 0s
    add(1, 3'b011, 0, 0, 8'h00, 8'h00, 0, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'h80, 1, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h40, 2, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'hA0, 3, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'hD0, 4, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h68, 5, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h34, 6, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'h9A, 7, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h4D, 8, 1);
    add(1, 3'b001, 0, 0, 8'h00, 8'h26, 8, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h13, 8, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h09, 8, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h04, 8, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h02, 8, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h01, 8, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h00, 8, 0);
    // PISO / rotate
    add(1, 3'b011, 0, 0, 8'h81, 8'h81, 0, 0);
    add(1, 3'b101, 0, 0, 8'h00, 8'h03, 1, 0);
    add(1, 3'b101, 0, 0, 8'h00, 8'h06, 2, 0);
    add(1, 3'b101, 0, 0, 8'h00, 8'h0C, 3, 0);
    add(1, 3'b100, 0, 0, 8'h00, 8'h06, 4, 0);
    add(1, 3'b100, 0, 0, 8'h00, 8'h03, 5, 0);
    add(1, 3'b100, 0, 0, 8'h00, 8'h81, 6, 0);
    // En gating (mode ignored), reserved and hold modes
    add(0, 3'b001, 1, 1, 8'hFF, 8'h81, 6, 0);
    add(0, 3'b011, 1, 1, 8'hFF, 8'h81, 6, 0);
    add(0, 3'b110, 1, 1, 8'hFF, 8'h81, 6, 0);
    add(0, 3'b101, 1, 1, 8'hFF, 8'h81, 6, 0);
    add(1, 3'b111, 1, 1, 8'hFF, 8'h81, 6, 0);
    add(1, 3'b000, 1, 1, 8'hFF, 8'h81, 6, 0);
    // Mixed directions count; load at Cnt=7 wins over saturation
    add(1, 3'b010, 0, 1, 8'h00, 8'h03, 7, 0);
    add(1, 3'b011, 1, 1, 8'h3C, 8'h3C, 0, 0);
    add(1, 3'b010, 0, 0, 8'h00, 8'h78, 1, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'hBC, 2, 0);
    add(1, 3'b110, 0, 0, 8'h55, 8'h00, 0, 0);
    // Saturate, then En=0 right after Done, then clear at saturation
    add(1, 3'b101, 0, 0, 8'h00, 8'h00, 1, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h01, 2, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h03, 3, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h07, 4, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h0F, 5, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h1F, 6, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h3F, 7, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h7F, 8, 1);
    add(0, 3'b010, 0, 1, 8'h00, 8'h7F, 8, 0);
    add(1, 3'b110, 0, 0, 8'h00, 8'h00, 0, 0);

    // ---- reset between edges ----
    @(posedge Clk); #3;
    Rst_n = 1'b0;
    #1;
    chk_all("rst_async", 8'hA5, 0, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1, 3'b000, 0, 0, 8'h00);
    chk_all("rst_release", 8'hA5, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].sinr, vecs[i].sinl, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].cnt, vecs[i].done);
    end

    // ---- reset mid-word discards the partial count ----
    expq = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      step(1, 3'b001, 1, 0, 8'h00);
      expq = {1'b1, expq[W-1:1]};
      chk_all($sformatf("pre_rst%0d", i), expq, i, 0);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 8'hA5, 0, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    expq = 8'hA5;
    for (int i = 1; i <= W; i++) begin
      step(1, 3'b010, 0, 0, 8'h00);
      expq = {expq[W-2:0], 1'b0};
      chk_all($sformatf("post_rst%0d", i), expq, i, i == W);
    end
    step(1, 3'b010, 0, 0, 8'h00);
    chk_all("post_rst_sat", 8'h00, W, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, WIDTH bits wide.
- Supports hold, shift right, shift left, parallel load, rotate right, rotate left and synchronous clear, selected by a mode input.
- A shift counter tracks shifts since the last load or clear and pulses Done when a full word has been shifted.
- Building block for serializers, deserializers and delay lines; supersedes fixed 4-stage serial-in/serial-out chains.

Parameters:
WIDTH, 8, register width in bits; legal range >= 2.
RST_VAL, 0, value of Q after reset (WIDTH bits).
CW, $clog2(WIDTH+1), width of Cnt; derived, not to be overridden.

Ports:
Clk  input  1  rising-edge clock.
Rst_n  input  1  asynchronous active-low reset.
En  input  1  operation enable; 0 = hold all state.
Mode  input  3  operation select (encoding below).
SinR  input  1  serial input entering the MSB on shift right.
SinL  input  1  serial input entering the LSB on shift left.
Din  input  WIDTH  parallel load data.
Q  output  WIDTH  register contents.
SoutR  output  1  Q[0]; bit leaving on shift right.
SoutL  output  1  Q[WIDTH-1]; bit leaving on shift left.
Cnt  output  CW  shifts since last load/clear, saturating at WIDTH.
Full  output  1  Cnt == WIDTH.
Done  output  1  one-cycle pulse when Cnt reaches WIDTH.

Behaviour:
- Reset:
  - Rst_n low, asynchronously, forces Q=RST_VAL, Cnt=0, Done=0.
  - Deassertion takes effect at the next rising Clk edge.
  - Reset asserted mid-shift discards the partial word; no Done.
- All state updates on rising Clk when Rst_n=1.
- En=0: Q and Cnt hold; Done=0. Mode is ignored.
- En=1, Mode encoding:
  - 000 hold: Q and Cnt unchanged.
  - 001 shift right: Q <= {SinR, Q[WIDTH-1:1]}.
  - 010 shift left: Q <= {Q[WIDTH-2:0], SinL}.
  - 011 load: Q <= Din; Cnt <= 0.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 clear: Q <= 0 (not RST_VAL); Cnt <= 0.
  - 111 reserved: behaves as hold.
- Counter:
  - Modes 001, 010, 100 and 101 increment Cnt by 1, saturating at WIDTH; further shifts leave Cnt=WIDTH.
  - Shift direction does not affect counting; mixed left/right shifts all count.
- Done:
  - Registered. Done=1 for exactly one cycle in the cycle after the edge where Cnt goes WIDTH-1 -> WIDTH.
  - No repeat pulse while saturated.
  - A load or clear followed by WIDTH more shifts produces a fresh pulse.
- Full: combinational from Cnt.
- SoutR and SoutL: combinational from Q, so they reflect the registered state with zero added latency. Latency from Din/SinR/SinL to Q is 1 cycle.
- Load or clear on the same edge that would have saturated: load/clear wins; Cnt=0; no Done.
- Serial-in to serial-out latency over WIDTH shift-right cycles is WIDTH cycles (SinR reaches SoutR after WIDTH shifts).

Test Plan:
1. Reset: WIDTH=8, RST_VAL=8'hA5. Assert Rst_n low between clock edges -> Q=8'hA5, Cnt=0, Done=0 immediately, without waiting for a Clk edge.
2. SISO: load 8'h00, then shift right 8 cycles with SinR pattern 1,0,1,1,0,0,1,0 -> Q=8'h4D. SoutR replays the same bit sequence on cycles 8..15. Done pulses once after the 8th shift; Full=1 from then on.
3. PISO/rotate: load 8'h81, rotate left 3 -> Q=8'h0C, Cnt=3. Rotate right 3 -> Q=8'h81, Cnt=6.
4. En gating and reserved mode: mid-sequence, En=0 for 4 cycles -> Q/Cnt frozen, Done=0. Mode=111 with En=1 -> no change.
5. Saturation and priority: after Full, shift 2 more -> Cnt stays 8 with no second Done. Load on the edge where Cnt=7 with shift pending -> Cnt=0, no Done. Clear -> Q=8'h00 (not RST_VAL).
6. Reset mid-operation: Rst_n low at Cnt=5 -> Q=RST_VAL, Cnt=0. Resume shifting -> Done only after 8 new shifts.
